// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial line in, parallel frame word and status out
//
// Signals:
//   rx_in        serial line, idle high, asynchronous to clk
//   E[4:0]       last good frame data, E[0] = first data bit received
//   P            last good frame parity bit, passed through unchecked
//   frame_valid  one-cycle pulse, E/P just updated
//   frame_error  one-cycle pulse, stop bit sampled low
//   busy         receiver is inside a frame (not idle)
// Modports:
//   master  the receiver: samples rx_in, drives the frame outputs
//   slave   the line driver / frame consumer: drives rx_in, reads the outputs
interface serial_frame_receiver_if;
    logic       rx_in;
    logic [4:0] E;
    logic       P;
    logic       frame_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        input  rx_in,
        output E,
        output P,
        output frame_valid,
        output frame_error,
        output busy
    );

    modport slave (
        output rx_in,
        input  E,
        input  P,
        input  frame_valid,
        input  frame_error,
        input  busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - 5-data-bit + parity asynchronous serial frame deserializer
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (4..1024)
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_frame_receiver_if.master (rx_in in; E, P, frame_valid,
//          frame_error, busy out)
//
// Frame on the line, LSB first: start(0), D0..D4, P, stop(1).
// E/P are only updated by a frame whose stop bit is high; parity is not
// evaluated here.
module serial_frame_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_frame_receiver_if.master bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int H  = CLKS_PER_BIT / 2;

    // Terminal counts: one full bit period, and half a bit for the start sample
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(H - 1);
    localparam logic [2:0]    IDX_LAST_D   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [5:0]    shift_q;      // [4:0] data, [5] parity
    logic [4:0]    e_q;
    logic          p_q;
    logic          frame_valid_q;
    logic          frame_error_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            // Synchronizer resets to the idle level so reset never looks like a start bit
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            e_q           <= '0;
            p_q           <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync1_q       <= bus.rx_in;
            sync2_q       <= sync1_q;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                // Wait half a bit, then confirm the line is still low so a
                // short glitch does not start a frame.
                S_START: begin
                    if (cnt_q == CNT_HALF_END) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!sync2_q) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                // From here on every sample lands one full bit after the
                // previous one, i.e. near the middle of each bit.
                S_DATA: begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= sync2_q;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == IDX_LAST_D) begin
                            state_q <= S_PARITY;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_q      <= '0;
                        shift_q[5] <= sync2_q;
                        idx_q      <= idx_q + 3'd1;
                        state_q    <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_BIT_END) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            e_q           <= shift_q[4:0];
                            p_q           <= shift_q[5];
                            frame_valid_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            // E/P keep the last good frame
                            frame_error_q <= 1'b1;
                            state_q       <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                // A line held low (break) must not be read as a stream of
                // new start bits; wait for it to return to idle.
                S_WAIT_HIGH: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.E           = e_q;
    assign bus.P           = p_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - self-checking bench for serial_frame_receiver (CLKS_PER_BIT 16 and 4)
module tb_serial_frame_receiver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_frame_receiver_if bus16();
    serial_frame_receiver_if bus4();

    serial_frame_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.master)
    );

    serial_frame_receiver #(.CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    // Rising-edge counter: after edge N has happened, cyc == N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       err;
        logic [4:0] e;
        logic       p;
    } pulse_t;

    pulse_t q16[$];
    pulse_t q4[$];
    int     both_cnt = 0;

    always @(negedge clk) begin
        pulse_t pl;
        if (bus16.frame_valid === 1'b1 || bus16.frame_error === 1'b1) begin
            pl.at = cyc; pl.err = bus16.frame_error; pl.e = bus16.E; pl.p = bus16.P;
            q16.push_back(pl);
        end
        if (bus4.frame_valid === 1'b1 || bus4.frame_error === 1'b1) begin
            pl.at = cyc; pl.err = bus4.frame_error; pl.e = bus4.E; pl.p = bus4.P;
            q4.push_back(pl);
        end
        if (bus16.frame_valid === 1'b1 && bus16.frame_error === 1'b1) both_cnt++;
        if (bus4.frame_valid === 1'b1 && bus4.frame_error === 1'b1) both_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a line level for n bit-clock cycles; returns 1 time unit after a rising edge
    task automatic line(input int which, input logic lvl, input int n);
        if (which == 16) bus16.rx_in = lvl;
        else             bus4.rx_in  = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full frame; t0 is the edge at which sync1 first sees the start bit
    task automatic send(input int which, input logic [4:0] d, input logic p,
                        input logic stop, output int t0);
        int c;
        c  = which;
        t0 = cyc + 1;
        line(which, 1'b0, c);
        for (int i = 0; i < 5; i++) line(which, d[i], c);
        line(which, p, c);
        line(which, stop, c);
    endtask

    // Reference timing: pulse visible in the cycle after the stop-bit sample edge
    function automatic int pulse_cycle(input int t0, input int c);
        return t0 + 2 + (c / 2) + 7 * c;
    endfunction

    task automatic expect_pulse(input int which, input string tag, input logic err,
                                input int at, input logic [4:0] ee, input logic ep);
        pulse_t pl;
        int     waited;
        waited = 0;
        while (((which == 16) ? q16.size() : q4.size()) == 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (((which == 16) ? q16.size() : q4.size()) == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            pl = (which == 16) ? q16.pop_front() : q4.pop_front();
            chk({tag, "_cycle"}, 32'(pl.at), 32'(at));
            chk({tag, "_kind"},  32'(pl.err), 32'(err));
            chk({tag, "_E"},     32'(pl.e), 32'(ee));
            chk({tag, "_P"},     32'(pl.p), 32'(ep));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [4:0] e16, e4;
    logic       p16, p4;
    int         t0, ta, tb;

    initial begin
        rst_n       = 1'b0;
        bus16.rx_in = 1'b1;
        bus4.rx_in  = 1'b1;
        e16 = '0; p16 = 1'b0; e4 = '0; p4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_E",    32'(bus16.E), 32'd0);
        chk("rst_P",    32'(bus16.P), 32'd0);
        chk("rst_fv",   32'(bus16.frame_valid), 32'd0);
        chk("rst_fe",   32'(bus16.frame_error), 32'd0);
        chk("rst_busy", 32'(bus16.busy), 32'd0);
        chk("rst4_busy", 32'(bus4.busy), 32'd0);

        rst_n = 1'b1;
        line(16, 1'b1, 5);
        chk("idle_busy", 32'(bus16.busy), 32'd0);

        // Single frame: data 1,0,1,1,0 -> E=01101, P=0
        send(16, 5'b01101, 1'b0, 1'b1, t0);
        line(16, 1'b1, 4);
        e16 = 5'b01101; p16 = 1'b0;
        expect_pulse(16, "single", 1'b0, t0 + 122, e16, p16);

        // Start glitch: 3 low cycles
        line(16, 1'b1, 2);
        line(16, 1'b0, 3);
        chk("glitch_busy_hi", 32'(bus16.busy), 32'd1);
        line(16, 1'b1, 11);
        chk("glitch_busy_lo", 32'(bus16.busy), 32'd0);
        chk("glitch_nopulse", 32'(q16.size()), 32'd0);
        chk("glitch_E", 32'(bus16.E), 32'(e16));
        chk("glitch_P", 32'(bus16.P), 32'(p16));

        // Framing error followed by a 50-cycle break
        line(16, 1'b1, 3);
        send(16, 5'b10010, 1'b1, 1'b0, t0);
        line(16, 1'b0, 50);
        expect_pulse(16, "ferr", 1'b1, pulse_cycle(t0, 16), e16, p16);
        chk("ferr_busy_hold", 32'(bus16.busy), 32'd1);
        line(16, 1'b1, 1);
        chk("ferr_busy_sync", 32'(bus16.busy), 32'd1);
        line(16, 1'b1, 3);
        chk("ferr_busy_drop", 32'(bus16.busy), 32'd0);
        chk("ferr_single", 32'(q16.size()), 32'd0);

        // Back-to-back frames, no idle gap
        line(16, 1'b1, 4);
        send(16, 5'b11111, 1'b0, 1'b1, ta);
        send(16, 5'b00000, 1'b1, 1'b1, tb);
        line(16, 1'b1, 10);
        expect_pulse(16, "b2b_a", 1'b0, pulse_cycle(ta, 16), 5'b11111, 1'b0);
        expect_pulse(16, "b2b_b", 1'b0, ta + 122 + 128, 5'b00000, 1'b1);
        e16 = 5'b00000; p16 = 1'b1;

        // Reset in the middle of data bit 2
        line(16, 1'b1, 4);
        line(16, 1'b0, 16);
        line(16, 1'b1, 16);
        line(16, 1'b1, 16);
        line(16, 1'b1, 8);
        chk("midrst_busy_before", 32'(bus16.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_E",    32'(bus16.E), 32'd0);
        chk("midrst_P",    32'(bus16.P), 32'd0);
        chk("midrst_busy", 32'(bus16.busy), 32'd0);
        chk("midrst_fv",   32'(bus16.frame_valid), 32'd0);
        chk("midrst_fe",   32'(bus16.frame_error), 32'd0);
        bus16.rx_in = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e16 = '0; p16 = 1'b0;
        line(16, 1'b1, 20);
        chk("midrst_nopulse", 32'(q16.size()), 32'd0);
        send(16, 5'b10110, 1'b1, 1'b1, t0);
        line(16, 1'b1, 4);
        e16 = 5'b10110; p16 = 1'b1;
        expect_pulse(16, "after_rst", 1'b0, pulse_cycle(t0, 16), e16, p16);

        // CLKS_PER_BIT = 4
        line(4, 1'b1, 4);
        send(4, 5'b10101, 1'b1, 1'b1, t0);
        line(4, 1'b1, 2);
        e4 = 5'b10101; p4 = 1'b1;
        expect_pulse(4, "c4_single", 1'b0, t0 + 32, e4, p4);

        // Randomized frames on both receivers against the reference model
        for (int n = 0; n < 30; n++) begin
            int         which;
            logic [4:0] d;
            logic       p, stop;
            which = ($urandom_range(0, 2) == 0) ? 4 : 16;
            d     = 5'($urandom);
            p     = 1'($urandom);
            stop  = ($urandom_range(0, 4) != 0);
            send(which, d, p, stop, t0);
            if (!stop) line(which, 1'b0, $urandom_range(0, 12));
            line(which, 1'b1, stop ? $urandom_range(0, 3) : $urandom_range(4, 8));
            if (which == 16) begin
                if (stop) begin e16 = d; p16 = p; end
                expect_pulse(16, $sformatf("rnd%0d_c16", n), !stop, pulse_cycle(t0, 16), e16, p16);
            end else begin
                if (stop) begin e4 = d; p4 = p; end
                expect_pulse(4, $sformatf("rnd%0d_c4", n), !stop, pulse_cycle(t0, 4), e4, p4);
            end
            line(which, 1'b1, 4);
        end

        line(16, 1'b1, 40);
        chk("end_q16_empty", 32'(q16.size()), 32'd0);
        chk("end_q4_empty",  32'(q4.size()), 32'd0);
        chk("never_both",    32'(both_cnt), 32'd0);
        chk("end_busy16",    32'(bus16.busy), 32'd0);
        chk("end_busy4",     32'(bus4.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
